// File: rtl/spi_pkg.sv
// Shared types and timing defaults for the SPI chip-select controller.
//   cs_state_t  : controller state encoding (IDLE, LEAD, ACTIVE, HOLD, LAG, GAP)
//   SPI_*       : default select-line count and CS timing in clk cycles
//   sel_width   : width of a slave index for a given select-line count (min 1)
//   dly_max     : largest of the three CS delays
//   cnt_width   : delay counter width able to hold dly_max (min 1)
package spi_pkg;

  typedef enum logic [2:0] {
    CS_IDLE,
    CS_LEAD,
    CS_ACTIVE,
    CS_HOLD,
    CS_LAG,
    CS_GAP
  } cs_state_t;

  localparam int SPI_NUM_SS      = 4;
  localparam int SPI_LEAD_CYCLES = 2;
  localparam int SPI_LAG_CYCLES  = 2;
  localparam int SPI_GAP_CYCLES  = 4;
  localparam int SPI_DLY_MAX     = 255;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dly_max(input int lead, input int lag, input int gap);
    int m;
    m = lead;
    if (lag > m) m = lag;
    if (gap > m) m = gap;
    return m;
  endfunction

  function automatic int cnt_width(input int lead, input int lag, input int gap);
    int m;
    m = dly_max(lead, lag, gap);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/cs_delay_cnt.sv
// Loadable down-counter shared by the LEAD, LAG and GAP phases.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load 'value' (clipped to MAX) this cycle
//   value    : load value
//   zero     : count is zero; the counter stops there until reloaded
module cs_delay_cnt
  import spi_pkg::*;
#(
  parameter int W   = 8,
  parameter int MAX = SPI_DLY_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  // A load never exceeds the largest programmed delay, so the count cannot wrap.
  function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
    if (32'(v) > MAX) return W'(MAX);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= sat_load(value);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_cs_ctrl.sv
// Multi-slave SPI chip-select controller.
// Asserts one of NUM_SS select lines per request, enforces CS-to-clock lead,
// clock-to-CS lag and a minimum deselect gap, and pulses 'start' to the shifter.
// With 'hold' set at 'done' the line stays asserted for a follow-up transfer
// to the same slave.
//   clk, rst  : clock, synchronous active-high reset
//   transmit  : request, accepted only while ready
//   slave_sel : target slave index, sampled with transmit
//   hold      : keep CS asserted after the transfer (sampled with done / in HOLD)
//   done      : one-cycle end-of-transfer pulse from the shifter
//   ss        : registered select lines, per-line polarity from SS_ACT_LVL
//   start     : one-cycle pulse to the shifter
//   ready     : a request would be accepted this cycle
//   busy      : a CS line is active or the deselect gap is running
//   err       : one-cycle pulse, cycle after a dropped request
module spi_cs_ctrl
  import spi_pkg::*;
#(
  parameter int                NUM_SS      = SPI_NUM_SS,
  parameter int                SEL_W       = sel_width(NUM_SS),
  parameter logic [NUM_SS-1:0] SS_ACT_LVL  = '0,
  parameter int                LEAD_CYCLES = SPI_LEAD_CYCLES,
  parameter int                LAG_CYCLES  = SPI_LAG_CYCLES,
  parameter int                GAP_CYCLES  = SPI_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              transmit,
  input  logic [SEL_W-1:0]  slave_sel,
  input  logic              hold,
  input  logic              done,
  output logic [NUM_SS-1:0] ss,
  output logic              start,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W   = cnt_width(LEAD_CYCLES, LAG_CYCLES, GAP_CYCLES);
  localparam int CNT_MAX = dly_max(LEAD_CYCLES, LAG_CYCLES, GAP_CYCLES);

  // The counter is loaded on entry to a timed phase and that entry cycle is
  // itself the first cycle of the phase, so it is loaded with length-1 and the
  // phase ends on the cycle it reads zero.
  localparam logic [CNT_W-1:0] LEAD_LD = (LEAD_CYCLES > 0) ? CNT_W'(LEAD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] LAG_LD  = (LAG_CYCLES  > 0) ? CNT_W'(LAG_CYCLES  - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES  > 0) ? CNT_W'(GAP_CYCLES  - 1) : '0;

  // Zero-length phases are skipped entirely.
  localparam cs_state_t AFTER_REQ  = (LEAD_CYCLES > 0) ? CS_LEAD : CS_ACTIVE;
  localparam cs_state_t AFTER_LAG  = (GAP_CYCLES  > 0) ? CS_GAP  : CS_IDLE;
  localparam cs_state_t AFTER_DONE = (LAG_CYCLES  > 0) ? CS_LAG  : AFTER_LAG;

  cs_state_t         state;
  cs_state_t         state_nxt;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_nxt;
  logic              sel_load;
  logic              sel_ok;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;
  logic              cs_on_nxt;
  logic              start_nxt;
  logic              err_nxt;
  logic [NUM_SS-1:0] ss_nxt;

  assign sel_ok = (32'(slave_sel) < NUM_SS);

  cs_delay_cnt #(
    .W   (CNT_W),
    .MAX (CNT_MAX)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CS_IDLE;
      ss    <= ~SS_ACT_LVL;
      start <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ss    <= ss_nxt;
      start <= start_nxt;
      err   <= err_nxt;
    end
  end

  // The selected index is only meaningful while a line is asserted.
  always_ff @(posedge clk) begin
    if (sel_load) sel_q <= slave_sel;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    sel_load  = 1'b0;
    case (state)
      CS_IDLE: begin
        if (transmit) begin
          if (sel_ok) begin
            sel_load  = 1'b1;
            state_nxt = AFTER_REQ;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CS_LEAD: begin
        err_nxt = transmit;
        if (cnt_zero) state_nxt = CS_ACTIVE;
      end
      CS_ACTIVE: begin
        err_nxt = transmit;
        if (done) state_nxt = hold ? CS_HOLD : AFTER_DONE;
      end
      CS_HOLD: begin
        // A request beats a released hold in the same cycle; only the
        // already-selected slave can reuse the asserted line.
        if (transmit) begin
          if (slave_sel == sel_q) state_nxt = CS_ACTIVE;
          else                    err_nxt   = 1'b1;
        end else if (!hold) begin
          state_nxt = AFTER_DONE;
        end
      end
      CS_LAG: begin
        err_nxt = transmit;
        if (cnt_zero) state_nxt = AFTER_LAG;
      end
      CS_GAP: begin
        err_nxt = transmit;
        if (cnt_zero) state_nxt = CS_IDLE;
      end
      default: state_nxt = CS_IDLE;
    endcase
  end

  // Derived from the next state so that ss and start line up with the state
  // register: every entry into ACTIVE (from IDLE, LEAD or HOLD) starts a transfer.
  always_comb begin
    start_nxt = (state_nxt == CS_ACTIVE) && (state != CS_ACTIVE);
    cnt_load  = (state_nxt != state) &&
                ((state_nxt == CS_LEAD) || (state_nxt == CS_LAG) || (state_nxt == CS_GAP));
    case (state_nxt)
      CS_LEAD: cnt_val = LEAD_LD;
      CS_LAG:  cnt_val = LAG_LD;
      CS_GAP:  cnt_val = GAP_LD;
      default: cnt_val = '0;
    endcase
    sel_nxt   = sel_load ? slave_sel : sel_q;
    cs_on_nxt = (state_nxt == CS_LEAD) || (state_nxt == CS_ACTIVE) ||
                (state_nxt == CS_HOLD) || (state_nxt == CS_LAG);
    for (int i = 0; i < NUM_SS; i++) begin
      ss_nxt[i] = (cs_on_nxt && (sel_nxt == SEL_W'(i))) ? SS_ACT_LVL[i] : ~SS_ACT_LVL[i];
    end
  end

  assign ready = (state == CS_IDLE) || (state == CS_HOLD);
  assign busy  = (state != CS_IDLE);

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Bench for spi_cs_ctrl: a default-timing instance (3-bit select so that
// out-of-range indices can be driven) and a zero-delay instance with a mixed
// active-level mask. Expected per-cycle outputs are queued when stimulus is
// issued; a monitor per instance compares them as the cycles come up and flags
// any start/err pulse that no expectation accounts for.
module tb_spi_cs_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] ss;
    logic       st;
    logic       er;
    logic       rdy;
    logic       bsy;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // default-timing instance
  logic       d_transmit, d_hold, d_done;
  logic [2:0] d_sel;
  logic [3:0] d_ss;
  logic       d_start, d_ready, d_busy, d_err;

  // zero-delay instance
  logic       z_transmit, z_hold, z_done;
  logic [1:0] z_sel;
  logic [3:0] z_ss;
  logic       z_start, z_ready, z_busy, z_err;

  exp_t qd[$];
  exp_t qz[$];
  exp_t e_d, e_z;
  bit   seen_d, seen_z;

  spi_cs_ctrl #(
    .NUM_SS(4), .SEL_W(3), .SS_ACT_LVL(4'b0000),
    .LEAD_CYCLES(2), .LAG_CYCLES(2), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .transmit(d_transmit), .slave_sel(d_sel),
    .hold(d_hold), .done(d_done), .ss(d_ss), .start(d_start),
    .ready(d_ready), .busy(d_busy), .err(d_err)
  );

  spi_cs_ctrl #(
    .NUM_SS(4), .SS_ACT_LVL(4'b0010),
    .LEAD_CYCLES(0), .LAG_CYCLES(0), .GAP_CYCLES(0)
  ) dut_z (
    .clk(clk), .rst(rst), .transmit(z_transmit), .slave_sel(z_sel),
    .hold(z_hold), .done(z_done), .ss(z_ss), .start(z_start),
    .ready(z_ready), .busy(z_busy), .err(z_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input bit to_z, input int c, input logic [3:0] s, input logic st,
                      input logic er, input logic rdy, input logic bsy, input string n);
    exp_t e;
    e.cyc = c; e.ss = s; e.st = st; e.er = er; e.rdy = rdy; e.bsy = bsy; e.name = n;
    if (to_z) qz.push_back(e);
    else      qd.push_back(e);
  endtask

  task automatic cmp(input string n, input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", n, cyc, act, expv);
    end
  endtask

  task automatic check_entry(input exp_t e, input logic [3:0] s, input logic st,
                             input logic er, input logic rdy, input logic bsy);
    cmp({e.name, ".ss"},    s,           e.ss);
    cmp({e.name, ".start"}, {3'b0, st},  {3'b0, e.st});
    cmp({e.name, ".err"},   {3'b0, er},  {3'b0, e.er});
    cmp({e.name, ".ready"}, {3'b0, rdy}, {3'b0, e.rdy});
    cmp({e.name, ".busy"},  {3'b0, bsy}, {3'b0, e.bsy});
  endtask

  always @(negedge clk) begin
    seen_d = 1'b0;
    while (qd.size() > 0 && qd[0].cyc <= cyc) begin
      e_d = qd.pop_front();
      if (e_d.cyc < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL %s cycle %0d not evaluated (now %0d)", e_d.name, e_d.cyc, cyc);
      end else begin
        seen_d = 1'b1;
        check_entry(e_d, d_ss, d_start, d_err, d_ready, d_busy);
      end
    end
    if (!seen_d && (d_start === 1'b1 || d_err === 1'b1)) begin
      n_checks++; n_errors++;
      $display("FAIL d_unexpected_pulse cyc=%0d start=%b err=%b required start=0 err=0",
               cyc, d_start, d_err);
    end
  end

  always @(negedge clk) begin
    seen_z = 1'b0;
    while (qz.size() > 0 && qz[0].cyc <= cyc) begin
      e_z = qz.pop_front();
      if (e_z.cyc < cyc) begin
        n_checks++; n_errors++;
        $display("FAIL %s cycle %0d not evaluated (now %0d)", e_z.name, e_z.cyc, cyc);
      end else begin
        seen_z = 1'b1;
        check_entry(e_z, z_ss, z_start, z_err, z_ready, z_busy);
      end
    end
    if (!seen_z && (z_start === 1'b1 || z_err === 1'b1)) begin
      n_checks++; n_errors++;
      $display("FAIL z_unexpected_pulse cyc=%0d start=%b err=%b required start=0 err=0",
               cyc, z_start, z_err);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    d_transmit = 1'b0; d_hold = 1'b0; d_done = 1'b0; d_sel = '0;
    z_transmit = 1'b0; z_hold = 1'b0; z_done = 1'b0; z_sel = '0;
    tick(); tick();
    push(0, cyc, 4'b1111, 0, 0, 1, 0, "rst_d");
    push(1, cyc, 4'b1101, 0, 0, 1, 0, "rst_z");
    rst = 1'b0;
    tick();

    // basic transfer: sel=2, done ten cycles after the request
    t = cyc;
    push(0, t,      4'b1111, 0, 0, 1, 0, "b_idle");
    push(0, t + 1,  4'b1011, 0, 0, 0, 1, "b_assert");
    push(0, t + 2,  4'b1011, 0, 0, 0, 1, "b_lead");
    push(0, t + 3,  4'b1011, 1, 0, 0, 1, "b_start");
    push(0, t + 4,  4'b1011, 0, 0, 0, 1, "b_active");
    push(0, t + 12, 4'b1011, 0, 0, 0, 1, "b_lag_end");
    push(0, t + 13, 4'b1111, 0, 0, 0, 1, "b_deassert");
    push(0, t + 16, 4'b1111, 0, 0, 0, 1, "b_gap_end");
    push(0, t + 17, 4'b1111, 0, 0, 1, 0, "b_ready");
    d_transmit = 1'b1; d_sel = 3'd2;
    tick(); d_transmit = 1'b0;
    wait_to(t + 10); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 18);

    // hold: reuse sel=1 without deassert, then a foreign request in HOLD
    t = cyc;
    push(0, t,      4'b1111, 0, 0, 1, 0, "h_idle");
    push(0, t + 1,  4'b1101, 0, 0, 0, 1, "h_assert");
    push(0, t + 3,  4'b1101, 1, 0, 0, 1, "h_start");
    push(0, t + 6,  4'b1101, 0, 0, 1, 1, "h_hold");
    push(0, t + 7,  4'b1101, 0, 0, 1, 1, "h_hold2");
    push(0, t + 8,  4'b1101, 1, 0, 0, 1, "h_restart");
    push(0, t + 11, 4'b1101, 0, 0, 1, 1, "h_hold3");
    push(0, t + 13, 4'b1101, 0, 1, 1, 1, "h_err");
    push(0, t + 14, 4'b1101, 0, 0, 0, 1, "h_lag");
    push(0, t + 15, 4'b1101, 0, 0, 0, 1, "h_lag_end");
    push(0, t + 16, 4'b1111, 0, 0, 0, 1, "h_deassert");
    push(0, t + 20, 4'b1111, 0, 0, 1, 0, "h_ready");
    d_transmit = 1'b1; d_sel = 3'd1;
    tick(); d_transmit = 1'b0;
    wait_to(t + 5); d_done = 1'b1; d_hold = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 7); d_transmit = 1'b1; d_sel = 3'd1;
    tick(); d_transmit = 1'b0;
    wait_to(t + 10); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 12); d_transmit = 1'b1; d_sel = 3'd3;
    tick(); d_transmit = 1'b0; d_hold = 1'b0;
    wait_to(t + 21);

    // dropped requests: bad index, during LEAD, during GAP; stray done
    t = cyc;
    push(0, t,      4'b1111, 0, 0, 1, 0, "d_idle0");
    push(0, t + 1,  4'b1111, 0, 1, 1, 0, "d_badsel");
    push(0, t + 2,  4'b1111, 0, 0, 1, 0, "d_idle1");
    push(0, t + 3,  4'b1110, 0, 0, 0, 1, "d_assert");
    push(0, t + 4,  4'b1110, 0, 1, 0, 1, "d_lead_err");
    push(0, t + 5,  4'b1110, 1, 0, 0, 1, "d_start");
    push(0, t + 10, 4'b1111, 0, 0, 0, 1, "d_deassert");
    push(0, t + 12, 4'b1111, 0, 1, 0, 1, "d_gap_err");
    push(0, t + 13, 4'b1111, 0, 0, 0, 1, "d_gap_end");
    push(0, t + 14, 4'b1111, 0, 0, 1, 0, "d_ready");
    push(0, t + 15, 4'b1111, 0, 0, 1, 0, "d_done_idle");
    d_transmit = 1'b1; d_sel = 3'd5;
    tick(); d_transmit = 1'b0;
    tick(); d_transmit = 1'b1; d_sel = 3'd0;
    tick(); d_sel = 3'd3;
    tick(); d_transmit = 1'b0;
    wait_to(t + 7); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 11); d_transmit = 1'b1; d_sel = 3'd2;
    tick(); d_transmit = 1'b0; d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 14); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 16);

    // reset while ACTIVE, later done ignored, next request without a gap
    t = cyc;
    push(0, t,      4'b1111, 0, 0, 1, 0, "r_idle");
    push(0, t + 1,  4'b0111, 0, 0, 0, 1, "r_assert");
    push(0, t + 3,  4'b0111, 1, 0, 0, 1, "r_start");
    push(0, t + 5,  4'b0111, 0, 0, 0, 1, "r_active");
    push(0, t + 6,  4'b1111, 0, 0, 1, 0, "r_reset");
    push(0, t + 8,  4'b1111, 0, 0, 1, 0, "r_done_ign");
    push(0, t + 9,  4'b1111, 0, 0, 1, 0, "r_idle2");
    push(0, t + 10, 4'b1110, 0, 0, 0, 1, "r_assert2");
    push(0, t + 12, 4'b1110, 1, 0, 0, 1, "r_start2");
    push(0, t + 20, 4'b1111, 0, 0, 1, 0, "r_ready");
    d_transmit = 1'b1; d_sel = 3'd3;
    tick(); d_transmit = 1'b0;
    wait_to(t + 5); rst = 1'b1;
    tick(); rst = 1'b0;
    tick(); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 9); d_transmit = 1'b1; d_sel = 3'd0;
    tick(); d_transmit = 1'b0;
    wait_to(t + 13); d_done = 1'b1;
    tick(); d_done = 1'b0;
    wait_to(t + 21);

    // zero delays, line 1 active high: immediate start/release, HOLD -> IDLE
    t = cyc;
    push(1, t,     4'b1101, 0, 0, 1, 0, "z_idle");
    push(1, t + 1, 4'b1001, 1, 0, 0, 1, "z_start");
    push(1, t + 2, 4'b1001, 0, 0, 0, 1, "z_active");
    push(1, t + 4, 4'b1001, 0, 0, 0, 1, "z_done_cyc");
    push(1, t + 5, 4'b1101, 0, 0, 1, 0, "z_release");
    push(1, t + 6, 4'b1111, 1, 0, 0, 1, "z_start2");
    push(1, t + 7, 4'b1111, 0, 0, 1, 1, "z_hold");
    push(1, t + 8, 4'b1101, 0, 0, 1, 0, "z_unhold");
    z_transmit = 1'b1; z_sel = 2'd2;
    tick(); z_transmit = 1'b0;
    wait_to(t + 4); z_done = 1'b1;
    tick(); z_done = 1'b0; z_transmit = 1'b1; z_sel = 2'd1;
    tick(); z_transmit = 1'b0; z_done = 1'b1; z_hold = 1'b1;
    tick(); z_done = 1'b0; z_hold = 1'b0;
    wait_to(t + 11);

    if (qd.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL qd_drain actual=%0d pending required=0", qd.size());
    end
    if (qz.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL qz_drain actual=%0d pending required=0", qz.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_cs_ctrl.md
# spi_cs_ctrl

Multi-slave SPI chip-select controller, parametrised successor of the single-line slave-select register. Sits between the transaction requester and the SPI shift engine: on a request it asserts one of `NUM_SS` select lines, enforces programmable CS-to-clock lead, clock-to-CS lag and minimum deselect gap, and issues the `start` pulse to the shifter. An optional hold mode keeps CS asserted across back-to-back transfers to the same slave.

## Interface
- `NUM_SS`, 4, number of select lines (1..16)
- `SEL_W`, `$clog2(NUM_SS)` (min 1), width of `slave_sel`
- `SS_ACT_LVL`, `{NUM_SS{1'b0}}`, per-line active level; bit i=0 means line i is active low
- `LEAD_CYCLES`, 2, cycles from CS assert to `start` (0..255)
- `LAG_CYCLES`, 2, cycles from `done` to CS deassert (0..255)
- `GAP_CYCLES`, 4, minimum cycles with all CS inactive before next request accepted (0..255)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `transmit` in 1: request, sampled only when `ready`=1
- `slave_sel` in `SEL_W`: target slave, sampled with `transmit`
- `hold` in 1: sampled with `done`; 1 keeps CS asserted after the transfer
- `done` in 1: one-cycle end-of-transfer pulse from shifter
- `ss` out `NUM_SS`: registered select lines
- `start` out 1: one-cycle pulse to shifter
- `ready` out 1: request will be accepted this cycle
- `busy` out 1: any CS line active or gap running
- `err` out 1: one-cycle pulse on dropped request

## Operation
- States: IDLE, LEAD, ACTIVE, HOLD, LAG, GAP. `ready` = (IDLE or HOLD); `busy` = not IDLE.
- Reset: state IDLE, `ss` = `~SS_ACT_LVL` (all inactive), `start`=0, `err`=0, counters 0. Applies mid-transfer: all CS inactive on the next cycle, no `start`, no gap enforced.
- IDLE + `transmit`: if `slave_sel` < `NUM_SS`, latch sel, assert `ss[sel]`, load counter with `LEAD_CYCLES`, go LEAD (direct to ACTIVE with `start` if `LEAD_CYCLES`=0). If `slave_sel` >= `NUM_SS`: `err` pulse, stay IDLE.
- LEAD: count down; at expiry pulse `start`, go ACTIVE.
- ACTIVE: wait for `done`. `done` with `hold`=1 -> HOLD; `hold`=0 -> LAG (counter = `LAG_CYCLES`), or directly GAP if `LAG_CYCLES`=0.
- HOLD: CS stays asserted. `transmit` to latched sel -> `start` next cycle, ACTIVE (no lead). `transmit` to other or invalid sel -> `err`, stay HOLD. `hold`=0 with no `transmit` -> LAG. `transmit` wins over `hold`=0 in the same cycle.
- LAG: count down; at expiry all CS inactive, counter = `GAP_CYCLES`, go GAP (or IDLE if 0).
- GAP: count down, then IDLE.
- `transmit` while `ready`=0 -> dropped, `err` pulse. `done` outside ACTIVE ignored.
- Exactly one CS line active at any time (one-hot in active-level terms).

## Timing
- `transmit` accepted in cycle T (IDLE): `ss[sel]` active from T+1; `start` high in cycle T+1+`LEAD_CYCLES`.
- `done` in cycle D, `hold`=0: CS active through D+`LAG_CYCLES`, inactive from D+1+`LAG_CYCLES`; `ready` high from D+1+`LAG_CYCLES`+`GAP_CYCLES`.
- `done` in D, `hold`=1: HOLD from D+1, `ready` high at D+1; `transmit` in H -> `start` in H+1.
- `err` high in the cycle after the offending request, one cycle.
- Counter width `$clog2(max(LEAD,LAG,GAP)+1)`, min 1; loads saturate at parameter value, no wrap.

## Structure
- Package `spi_pkg`: `cs_state_t` enum (6 states), shared SPI timing defaults.
- Sub-module `cs_delay_cnt`: loadable down-counter with `load`, `value`, `zero` flag; one instance shared by LEAD/LAG/GAP.
- Top holds FSM, sel latch, registered `ss`/`start`/`err`.

## Test plan
- Reset: `rst`=1 two cycles -> `ss`=4'b1111, `start`=0, `ready`=1, `busy`=0.
- Basic: `transmit` sel=2 at T, `done` at T+10 -> `ss`=4'b1011 T+1..T+12, `start` at T+3, `ready` at T+17.
- Zero delays (LEAD=LAG=GAP=0): `start` and `ss` assert at T+1; CS inactive and `ready` at D+1.
- Hold: sel=1, `done` with `hold`=1, `transmit` sel=1 two cycles later -> CS never deasserts, second `start` one cycle after request; `transmit` sel=3 in HOLD -> `err`, CS unchanged.
- Drops: `transmit` during LEAD and during GAP, and sel=5 with NUM_SS=4 in IDLE -> `err` pulse each, no state change.
- Reset mid-ACTIVE -> all CS inactive next cycle, IDLE, later `done` ignored.
